r408_dbus_arb: RTL

//  Two-master arbiter for the R408 8-bit data bus. Sits between the core LSU bus (m0) and a DMA/debug master (m1)
//  on one side and the single slave D-bus (RAM/peripherals) on the other. Round-robin grant, one transaction
//  in flight, registered slave strobes, per-transaction rdy timeout with error reporting.

---
 rtl/r408_bus_pkg.sv | 17 +
 rtl/r408_rr_pick.sv | 14 +
 rtl/r408_dbus_arb.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/r408_bus_pkg.sv
// Shared definitions for the R408 data-bus arbiter: FSM encoding, default widths
// and the read data returned to a master whose transaction timed out.
package r408_bus_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;

  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/r408_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins; on contention the
// master that was not granted last wins (last=1 means m1 was granted last).
module r408_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/r408_dbus_arb.sv
// Two-master arbiter for the R408 8-bit D-bus: round-robin grant, one transaction
// in flight, registered slave strobes and a per-transaction s_rdy timeout.
module r408_dbus_arb
  import r408_bus_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int TO_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_read,
  input  logic          m0_write,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rdy,
  output logic          m0_err,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_read,
  input  logic          m1_write,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rdy,
  output logic          m1_err,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_read,
  output logic          s_write,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_rdy,
  output logic [7:0]    err_cnt
);

  // Strobes are held for 2**TO_W-1 cycles: tcnt counts 0 .. all-ones-minus-one.
  localparam logic [TO_W-1:0] TO_FIRE = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  arb_state_e      state_q, state_d;
  logic            last_grant_q;
  logic [TO_W-1:0] tcnt_q;
  logic [7:0]      err_cnt_q;
  logic [AW-1:0]   s_addr_q;
  logic [DW-1:0]   s_wdata_q;
  logic            s_read_q, s_write_q;
  logic [DW-1:0]   m0_rdata_q, m1_rdata_q;
  logic            m0_rdy_q, m1_rdy_q, m0_err_q, m1_err_q;

  logic pick_g0, pick_g1;
  logic done_ok, done_to;

  r408_rr_pick u_pick (
    .req0 (m0_read | m0_write),
    .req1 (m1_read | m1_write),
    .last (last_grant_q),
    .gnt0 (pick_g0),
    .gnt1 (pick_g1)
  );

  always_comb begin
    state_d = state_q;
    done_ok = 1'b0;
    done_to = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_g0)      state_d = ARB_GNT0;
        else if (pick_g1) state_d = ARB_GNT1;
      end
      ARB_GNT0, ARB_GNT1: begin
        // A completion on the timeout cycle is treated as a normal completion.
        if (s_rdy) begin
          done_ok = 1'b1;
          state_d = ARB_DONE;
        end else if (tcnt_q == TO_FIRE) begin
          done_to = 1'b1;
          state_d = ARB_DONE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      tcnt_q       <= '0;
      err_cnt_q    <= '0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_read_q     <= 1'b0;
      s_write_q    <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_rdy_q     <= 1'b0;
      m1_rdy_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      m0_rdy_q <= 1'b0;
      m1_rdy_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          // read&write together counts as a write.
          if (pick_g0) begin
            s_addr_q     <= m0_addr;
            s_wdata_q    <= m0_wdata;
            s_write_q    <= m0_write;
            s_read_q     <= m0_read & ~m0_write;
            last_grant_q <= 1'b0;
          end else if (pick_g1) begin
            s_addr_q     <= m1_addr;
            s_wdata_q    <= m1_wdata;
            s_write_q    <= m1_write;
            s_read_q     <= m1_read & ~m1_write;
            last_grant_q <= 1'b1;
          end
        end
        ARB_GNT0, ARB_GNT1: begin
          if (done_ok || done_to) begin
            s_read_q  <= 1'b0;
            s_write_q <= 1'b0;
            if (state_q == ARB_GNT0) begin
              m0_rdy_q   <= 1'b1;
              m0_err_q   <= done_to;
              m0_rdata_q <= done_ok ? s_rdata : DW'(TIMEOUT_RDATA);
            end else begin
              m1_rdy_q   <= 1'b1;
              m1_err_q   <= done_to;
              m1_rdata_q <= done_ok ? s_rdata : DW'(TIMEOUT_RDATA);
            end
            if (done_to && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else begin
            tcnt_q <= tcnt_q + TO_ONE;
          end
        end
        default: tcnt_q <= '0;
      endcase
    end
  end

  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_read   = s_read_q;
  assign s_write  = s_write_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_rdy   = m0_rdy_q;
  assign m1_rdy   = m1_rdy_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign err_cnt  = err_cnt_q;

endmodule
